// File: rtl/canny_pkg.sv
`default_nettype none
// ============================================================================
// Module      : canny_pkg
// Description : Shared constants and types for the Canny front end. Defines the
//               pixel and window types, the grad_shift encoding and the
//               window_builder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package canny_pkg;

  localparam int PIX_W = 8;  // gradient stage consumes 8-bit pixels
  localparam int WIN   = 7;  // window edge length

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [0:WIN-1][0:WIN-1] window_t;

  // Selects which strip of the 7x7 window the shared gradient instance uses.
  typedef enum logic [1:0] {
    GS_NONE   = 2'b00,
    GS_RIGHT  = 2'b01,
    GS_LEFT   = 2'b10,
    GS_BOTTOM = 2'b11
  } grad_shift_t;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'b00,
    ST_EMIT01 = 2'b01,
    ST_EMIT10 = 2'b10,
    ST_EMIT11 = 2'b11
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : One image row of pixel storage. Single port addressed by the
//               column index; the read is combinational from the current
//               contents, so a same-cycle write returns the previous row's
//               pixel (read-before-write). Contents are never cleared.
// Ports       : clk      - rising-edge clock
//               we_i     - write enable (pixel accepted this cycle)
//               idx_i    - column index
//               wdata_i  - pixel written at idx_i
//               rdata_o  - pixel stored at idx_i before this cycle's write
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int PIX_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    idx_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[idx_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/window_builder.sv
`default_nettype none
// ============================================================================
// Module      : window_builder
// Description : Builds 7x7 pixel windows from a raster pixel stream using six
//               chained line buffers and a 7x7 shift-register window. Each
//               valid window is presented for three handshakes with
//               grad_shift = 01 (right), 10 (left), 11 (bottom) so a single
//               combinational gradient instance covers all three strips.
// Config      : SOF_RESYNC_EN - adds the sof input; a pixel accepted with
//               sof=1 is taken as row 0, col 0.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               pix_in/pix_valid/pix_ready - pixel stream input handshake
//               sof               - start of frame (SOF_RESYNC_EN only)
//               seven_buffer_out  - window [r][c], r=0 oldest row, c=0 oldest col
//               grad_shift        - strip select, 00 when win_valid=0
//               win_valid/win_ready - window output handshake
//               frame_done        - 1-cycle pulse after the last window of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module window_builder #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int PIX_W      = canny_pkg::PIX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PIX_W-1:0]              pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
`ifdef SOF_RESYNC_EN
  input  logic                          sof,
`endif
  output logic [0:6][0:6][PIX_W-1:0]    seven_buffer_out,
  output logic [1:0]                    grad_shift,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic                          frame_done
);

  import canny_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wb_state_t                   state_q;
  grad_shift_t                 grad_shift_q;
  logic                        win_valid_q;
  logic                        pix_ready_q;
  logic                        frame_done_q;
  logic                        last_q;      // current window is the frame's last
  logic [CW-1:0]               col_q;
  logic [RW-1:0]               row_q;
  logic [0:6][0:6][PIX_W-1:0]  window_q;

  // --------------------------------------------------------------------------
  // Next-state / combinational
  // --------------------------------------------------------------------------
  logic                        accept;
  logic [CW-1:0]               col_eff;     // coordinate of the pixel being accepted
  logic [RW-1:0]               row_eff;
  logic [CW-1:0]               col_d;
  logic [RW-1:0]               row_d;
  logic                        win_ok;
  logic                        is_last;
  logic [0:6][0:6][PIX_W-1:0]  window_d;
  logic [PIX_W-1:0]            lb_tap [WIN-1];

  // pix_ready is only ever high in ST_ACCEPT, so this is the accept strobe.
  assign accept = pix_valid && pix_ready_q;

  always_comb begin
    col_eff = col_q;
    row_eff = row_q;
`ifdef SOF_RESYNC_EN
    if (sof) begin
      col_eff = '0;
      row_eff = '0;
    end
`endif
    col_d = col_eff + CW'(1);
    row_d = row_eff;
    if (col_eff == CW'(IMG_WIDTH - 1)) begin
      col_d = '0;
      row_d = (row_eff == RW'(IMG_HEIGHT - 1)) ? '0 : row_eff + RW'(1);
    end
  end

  // Windows whose left edge would wrap into the previous row are suppressed.
  assign win_ok  = (row_eff >= RW'(WIN - 1)) && (col_eff >= CW'(WIN - 1));
  assign is_last = (row_eff == RW'(IMG_HEIGHT - 1)) && (col_eff == CW'(IMG_WIDTH - 1));

  // Shift one column left; the new right-hand column is the six line-buffer
  // taps (deepest buffer = oldest row) topped off by the incoming pixel.
  always_comb begin
    window_d = window_q;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        window_d[r][c] = window_q[r][c+1];
      end
    end
    for (int r = 0; r < WIN - 1; r++) begin
      window_d[r][WIN-1] = lb_tap[WIN-2-r];
    end
    window_d[WIN-1][WIN-1] = pix_in;
  end

  // --------------------------------------------------------------------------
  // Line buffers: buffer k holds the row k+1 above the incoming pixel. Each
  // buffer's read value is written into the next, pushing pixels down the chain.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    logic [PIX_W-1:0] wdata;
    if (k == 0) begin : g_head
      assign wdata = pix_in;
    end else begin : g_chain
      assign wdata = lb_tap[k-1];
    end

    line_buffer #(
      .DEPTH (IMG_WIDTH),
      .PIX_W (PIX_W),
      .AW    (CW)
    ) u_line_buffer (
      .clk     (clk),
      .we_i    (accept),
      .idx_i   (col_eff),
      .wdata_i (wdata),
      .rdata_o (lb_tap[k])
    );
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCEPT;
      grad_shift_q <= GS_NONE;
      win_valid_q  <= 1'b0;
      pix_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      window_q     <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_ACCEPT: begin
          pix_ready_q <= 1'b1;
          if (accept) begin
            col_q    <= col_d;
            row_q    <= row_d;
            window_q <= window_d;
            if (win_ok) begin
              state_q      <= ST_EMIT01;
              win_valid_q  <= 1'b1;
              grad_shift_q <= GS_RIGHT;
              pix_ready_q  <= 1'b0;
              last_q       <= is_last;
            end
          end
        end
        ST_EMIT01: begin
          if (win_ready) begin
            state_q      <= ST_EMIT10;
            grad_shift_q <= GS_LEFT;
          end
        end
        ST_EMIT10: begin
          if (win_ready) begin
            state_q      <= ST_EMIT11;
            grad_shift_q <= GS_BOTTOM;
          end
        end
        ST_EMIT11: begin
          if (win_ready) begin
            state_q      <= ST_ACCEPT;
            grad_shift_q <= GS_NONE;
            win_valid_q  <= 1'b0;
            pix_ready_q  <= 1'b1;
            frame_done_q <= last_q;
          end
        end
        default: begin
          state_q      <= ST_ACCEPT;
          grad_shift_q <= GS_NONE;
          win_valid_q  <= 1'b0;
          pix_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign pix_ready        = pix_ready_q;
  assign seven_buffer_out = window_q;
  assign grad_shift       = grad_shift_q;
  assign win_valid        = win_valid_q;
  assign frame_done       = frame_done_q;

endmodule
`default_nettype wire
